// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding word/halfword/byte responder in front of a 1-cycle-latency word RAM
// Optional MEM_RSP_ALIGN_CHECK_EN rejects misaligned and illegal-size requests with rsp_err.
module mem_responder #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

  state_t      state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic [31:0] wdata_q;

  logic        req_err;
  logic        req_word;
  logic [31:0] merged;
  logic [31:0] load_val;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W];

  // Size 11 only reaches the datapath when alignment checking is off, where it acts as a word.
  assign req_word = (req_size == 2'b00) || (req_size == 2'b11);

`ifdef MEM_RSP_ALIGN_CHECK_EN
  assign req_err = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b00) && (req_addr[1:0] != 2'b00));
`else
  assign req_err = 1'b0;
`endif

  // Lane insert for read-modify-write and lane extract for loads, both from the fresh RAM word.
  always_comb begin
    merged   = ram_rdata;
    load_val = ram_rdata;
    if (size_q == 2'b01) begin
      merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      load_val = {16'b0, ram_rdata[{off_q[1], 4'b0000} +: 16]};
    end else if (size_q == 2'b10) begin
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      load_val = {24'b0, ram_rdata[{off_q, 3'b000} +: 8]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'b0;
      rsp_err   <= 1'b0;
      ram_addr  <= 32'b0;
      ram_wr    <= 1'b0;
      ram_wdata <= 32'b0;
      off_q     <= 2'b0;
      size_q    <= 2'b0;
      write_q   <= 1'b0;
      wdata_q   <= 32'b0;
    end else begin
      rsp_valid <= 1'b0;
      ram_wr    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q     <= req_addr[1:0];
            size_q    <= req_size;
            write_q   <= req_write;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'b0;
            end else begin
              ram_addr <= {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W-1:2], 2'b00};
              if (req_write && req_word) begin
                state     <= WR;
                ram_wr    <= 1'b1;
                ram_wdata <= req_wdata;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: state <= RD_WAIT;
        RD_WAIT: begin
          if (write_q) begin
            state     <= WR;
            ram_wr    <= 1'b1;
            ram_wdata <= merged;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_val;
          end
        end
        WR: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'b0;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder with a word-array reference model
module tb_mem_responder;
  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  mem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  logic        ram_clear = 1'b1;
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'b0;
    end else if (ram_wr) begin
      ram[ram_addr[7:2]] <= ram_wdata;
    end
    ram_rdata <= ram[ram_addr[7:2]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          t_hs;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [64];
  int          checks = 0;
  int          errors = 0;
  int          wr_pulses = 0;
  int          exp_wr = 0;
  int          prev_hs = 0;
  int          prev_int = 0;
  bit          have_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic w, input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] rd,
                                output logic e, output int lat);
    int          idx;
    int          sh;
    logic [31:0] mask;
    logic [31:0] word;
    idx = int'(a[7:2]);
    e = 1'b0;
`ifdef MEM_RSP_ALIGN_CHECK_EN
    e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b00 && a[1:0] != 2'b00);
`endif
    rd  = 32'b0;
    lat = 1;
    if (!e) begin
      word = ref_mem[idx];
      if (sz == 2'b01) begin
        sh = a[1] ? 16 : 0;
        mask = 32'h0000_FFFF << sh;
      end else if (sz == 2'b10) begin
        sh = int'(a[1:0]) * 8;
        mask = 32'h0000_00FF << sh;
      end else begin
        sh = 0;
        mask = 32'hFFFF_FFFF;
      end
      if (w) begin
        ref_mem[idx] = (word & ~mask) | ((d << sh) & mask);
        lat = (sz == 2'b01 || sz == 2'b10) ? 4 : 2;
      end else begin
        rd  = (word & mask) >> sh;
        lat = 3;
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge after the handshake with req_valid still high.
  task automatic send(input logic w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input bit expect_rsp, input bit b2b);
    int          n;
    logic [31:0] rd;
    logic        e;
    int          lat;
    req_valid = 1'b1;
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (b2b && have_prev) chk("issue_interval", 32'(cyc - prev_hs), 32'(prev_int));
    if (expect_rsp) begin
      model(w, sz, a, d, rd, e, lat);
      if (w && !e) exp_wr++;
      sb.push_back('{rdata: rd, err: e, t_hs: cyc, lat: lat});
      prev_int  = lat + 1;
      have_prev = 1;
    end
    prev_hs = cyc;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    req_valid = 1'b0;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'(sb.size()), 32'd0);
    have_prev = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
    chk({tag, "_ram_addr"},  ram_addr, 32'd0);
    chk({tag, "_ram_wr"},    32'(ram_wr), 32'd0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge clk);
          if (rsp_valid) begin
            if (sb.size() == 0) begin
              chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
              mon_e = sb.pop_front();
              chk("rsp_rdata", rsp_rdata, mon_e.rdata);
              chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
              chk("rsp_latency", 32'(cyc - mon_e.t_hs), 32'(mon_e.lat));
            end
          end
          if (ram_wr) begin
            wr_pulses++;
            chk("ram_addr_aligned", ram_addr & ~32'h0000_00FC, 32'd0);
          end
        end
      end
      begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'b0;
        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        ram_clear = 1'b0;
        @(negedge clk);

        send(1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 1, 0); wait_idle();
        send(0, 2'b00, 32'h0000_0010, 32'h0, 1, 0);         wait_idle();
        send(1, 2'b00, 32'h0000_0020, 32'h1122_3344, 1, 0); wait_idle();
        send(1, 2'b10, 32'h0000_0021, 32'h0000_00AA, 1, 0); wait_idle();
        chk("rmw_byte_ram", ram[8], 32'h1122_AA44);
        send(0, 2'b01, 32'h0000_0022, 32'h0, 1, 0);         wait_idle();
        send(1, 2'b00, 32'h0000_0030, 32'h80FF_0001, 1, 0); wait_idle();
        send(0, 2'b10, 32'h0000_0033, 32'h0, 1, 0);         wait_idle();
        send(0, 2'b01, 32'h0000_0021, 32'h0, 1, 0);         wait_idle();
        send(0, 2'b00, 32'hFFFF_FF23, 32'h0, 1, 0);         wait_idle();
        send(1, 2'b11, 32'h0000_0034, 32'h1234_5678, 1, 0); wait_idle();

        for (int i = 0; i < 30; i++) begin
          send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 31)), $urandom(), 1, 0);
          req_valid = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        for (int i = 0; i < 30; i++) begin
          send(1'(i % 2), 2'($urandom_range(0, 3)),
               ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 31)), $urandom(), 1, 1);
        end
        wait_idle();

        // Reset lands in RD_WAIT of a byte store; the RAM word must survive untouched.
        send(1, 2'b00, 32'h0000_0040, 32'hCAFE_BABE, 1, 0); wait_idle();
        send(1, 2'b10, 32'h0000_0041, 32'h0000_0055, 0, 0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("rmw_interrupted_ram", ram[16], 32'hCAFE_BABE);
        send(0, 2'b10, 32'h0000_0041, 32'h0, 1, 0); wait_idle();

        chk("ram_wr_pulses", 32'(wr_pulses), 32'(exp_wr));
        for (int i = 0; i < 64; i++) chk("final_ram", ram[i], ref_mem[i]);
      end
      begin
        #2000000;
        chk("watchdog", 32'd1, 32'd0);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
